// File: rtl/updown_tracker_pkg.sv
// Shared types and constants for the up/down count tracker.
package updown_tracker_pkg;

  localparam int unsigned ERR_CNT_W = 8;

  typedef enum logic [1:0] {
    UNLOCKED = 2'd0,
    TRACK    = 2'd1,
    FAULT    = 2'd2
  } track_state_e;

  typedef enum logic [2:0] {
    HOLD    = 3'd0,
    INC     = 3'd1,
    DEC     = 3'd2,
    WRAP_UP = 3'd3,
    WRAP_DN = 3'd4,
    ILLEGAL = 3'd5
  } step_class_e;

endpackage

// File: rtl/updown_count_tracker_classifier.sv
// Classifies one observed count sample against the previous one.
module updown_step_classifier
  import updown_tracker_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] in_count,
  input  logic             in_overflow,
  output step_class_e      step_class
);

  localparam int unsigned W1 = WIDTH + 1;

  logic [WIDTH:0] p_ext;
  logic [WIDTH:0] c_ext;
  logic [WIDTH:0] max_ext;

  assign p_ext   = {1'b0, prev};
  assign c_ext   = {1'b0, in_count};
  assign max_ext = W1'(MAX_COUNT);

  // Unit steps use a widened compare so a flagless wrap never aliases to INC/DEC.
  always_comb begin
    step_class = ILLEGAL;
    if (c_ext > max_ext) begin
      step_class = ILLEGAL;
    end else if (p_ext == max_ext && c_ext == '0 && in_overflow) begin
      step_class = WRAP_UP;
    end else if (p_ext == '0 && c_ext == max_ext && in_overflow) begin
      step_class = WRAP_DN;
    end else if (c_ext == p_ext) begin
      step_class = HOLD;
    end else if (c_ext == p_ext + W1'(1) && !in_overflow) begin
      step_class = INC;
    end else if (c_ext + W1'(1) == p_ext && !in_overflow) begin
      step_class = DEC;
    end
  end

endmodule

// File: rtl/updown_count_tracker.sv
// Rebuilds an extended position from a narrow up/down wrap counter and flags illegal transitions.
module updown_count_tracker
  import updown_tracker_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_COUNT = (1 << WIDTH) - 1,
  parameter int unsigned EXT_WIDTH = 16,
  parameter int unsigned ERR_LIMIT = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync_req,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_count,
  input  logic                 in_overflow,
  output logic [EXT_WIDTH-1:0] position,
  output logic                 locked,
  output logic                 dir,
  output logic                 step_pulse,
  output logic                 wrap_up_pulse,
  output logic                 wrap_dn_pulse,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
);

  localparam int unsigned CERR_W = $clog2(ERR_LIMIT + 1);

  track_state_e         state_q, state_d;
  step_class_e          cls;
  logic [WIDTH-1:0]     prev_q, prev_d;
  logic [EXT_WIDTH-1:0] pos_q, pos_d;
  logic [CERR_W-1:0]    cerr_q, cerr_d;
  logic [ERR_CNT_W-1:0] errc_q, errc_d;
  logic                 locked_q, locked_d;
  logic                 dir_q, dir_d;
  logic                 step_q, step_d;
  logic                 wup_q, wup_d;
  logic                 wdn_q, wdn_d;
  logic                 err_q, err_d;

  updown_step_classifier #(
    .WIDTH     (WIDTH),
    .MAX_COUNT (MAX_COUNT)
  ) u_classifier (
    .prev        (prev_q),
    .in_count    (in_count),
    .in_overflow (in_overflow),
    .step_class  (cls)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= UNLOCKED;
      prev_q   <= '0;
      pos_q    <= '0;
      cerr_q   <= '0;
      errc_q   <= '0;
      locked_q <= 1'b0;
      dir_q    <= 1'b0;
      step_q   <= 1'b0;
      wup_q    <= 1'b0;
      wdn_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= prev_d;
      pos_q    <= pos_d;
      cerr_q   <= cerr_d;
      errc_q   <= errc_d;
      locked_q <= locked_d;
      dir_q    <= dir_d;
      step_q   <= step_d;
      wup_q    <= wup_d;
      wdn_q    <= wdn_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    prev_d  = prev_q;
    pos_d   = pos_q;
    cerr_d  = cerr_q;
    errc_d  = errc_q;
    dir_d   = dir_q;
    step_d  = 1'b0;
    wup_d   = 1'b0;
    wdn_d   = 1'b0;
    err_d   = 1'b0;

    if (sync_req) begin
      state_d = UNLOCKED;
      cerr_d  = '0;
    end else if (in_valid) begin
      case (state_q)
        UNLOCKED: begin
          prev_d  = in_count;
          pos_d   = EXT_WIDTH'(in_count);
          state_d = TRACK;
        end
        TRACK: begin
          // Re-anchor on every sample, illegal ones included.
          prev_d = in_count;
          case (cls)
            HOLD: cerr_d = '0;
            INC, WRAP_UP: begin
              pos_d  = pos_q + EXT_WIDTH'(1);
              dir_d  = 1'b1;
              step_d = 1'b1;
              wup_d  = (cls == WRAP_UP);
              cerr_d = '0;
            end
            DEC, WRAP_DN: begin
              pos_d  = pos_q - EXT_WIDTH'(1);
              dir_d  = 1'b0;
              step_d = 1'b1;
              wdn_d  = (cls == WRAP_DN);
              cerr_d = '0;
            end
            default: begin
              err_d  = 1'b1;
              errc_d = (errc_q == '1) ? errc_q : errc_q + ERR_CNT_W'(1);
              cerr_d = cerr_q + CERR_W'(1);
              if (cerr_d == CERR_W'(ERR_LIMIT)) begin
                state_d = FAULT;
              end
            end
          endcase
        end
        default: ;
      endcase
    end

    locked_d = (state_d == TRACK);
  end

  assign position      = pos_q;
  assign locked        = locked_q;
  assign dir           = dir_q;
  assign step_pulse    = step_q;
  assign wrap_up_pulse = wup_q;
  assign wrap_dn_pulse = wdn_q;
  assign err_pulse     = err_q;
  assign err_count     = errc_q;

endmodule

// File: doc/updown_count_tracker.md
Name: updown_count_tracker

Overview:
Receive-side companion to the team's up/down wrap counter. It samples a narrow WIDTH-bit count and its overflow/underflow flag and classifies each sample as hold, step or wrap. From that it rebuilds an EXT_WIDTH-bit extended position and direction, and flags illegal transitions such as missed steps or a bad wrap flag. It sits downstream of counter instances, for example in position or event monitors, and needs no access to the counter's internals.

Parameters:
WIDTH, 4, width of the observed count.
MAX_COUNT, (1<<WIDTH)-1, wrap point of the observed counter; must be >= 1.
EXT_WIDTH, 16, width of the reconstructed position; must be > WIDTH.
ERR_LIMIT, 3, consecutive illegal samples that force FAULT; must be >= 1.

Ports:
clk  in  1  sole clock; all logic on rising edge.
rst  in  1  asynchronous, active-high reset.
sync_req  in  1  resynchronise request; single-cycle pulse, level tolerated.
in_valid  in  1  sample strobe; tie to the source counter's enable, delayed one cycle.
in_count  in  WIDTH  observed count.
in_overflow  in  1  observed overflow/underflow flag.
position  out  EXT_WIDTH  reconstructed position, modulo 2^EXT_WIDTH.
locked  out  1  high in TRACK state.
dir  out  1  direction of last step; 1 = up, 0 = down.
step_pulse  out  1  one cycle per accepted +/-1 step.
wrap_up_pulse  out  1  one cycle per accepted MAX_COUNT->0 wrap.
wrap_dn_pulse  out  1  one cycle per accepted 0->MAX_COUNT wrap.
err_pulse  out  1  one cycle per illegal sample.
err_count  out  8  total illegal samples; saturates at 255.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rst).
- Reset values:
  - All outputs are 0 and the state is UNLOCKED.
  - The internal prev register and the consecutive-error counter (cerr) are 0.
- Timing: all outputs are registered. A sample taken at edge N is reflected in the outputs after edge N+1. Pulses are high for exactly one cycle.
- Priority: rst > sync_req > in_valid.
- sync_req:
  - Moves to UNLOCKED and clears cerr and locked.
  - position, dir and err_count hold their values.
  - Any sample presented in the same cycle is discarded.
- States:
  - UNLOCKED: on the first in_valid, prev <= in_count, position <= zero-extended in_count, locked <= 1, go to TRACK. No pulses, and in_overflow is ignored.
  - TRACK: classify every in_valid sample as below.
  - FAULT: locked = 0 and all samples are ignored; only sync_req or rst leaves this state.
- Classification (TRACK only), evaluated in priority order p = prev, c = in_count:
  - c > MAX_COUNT -> ILLEGAL.
  - p == MAX_COUNT and c == 0 and in_overflow -> WRAP_UP: position +1, dir 1, step_pulse and wrap_up_pulse.
  - p == 0 and c == MAX_COUNT and in_overflow -> WRAP_DN: position -1, dir 0, step_pulse and wrap_dn_pulse.
  - c == p -> HOLD: nothing changes, and in_overflow is don't-care. The source flag persists while the counter is disabled.
  - c == p+1 and !in_overflow -> INC: position +1, dir 1, step_pulse.
  - c == p-1 and !in_overflow -> DEC: position -1, dir 0, step_pulse.
  - Otherwise -> ILLEGAL. This covers jumps, a wrap seen without the flag, and the flag set on a non-wrap step.
- prev <= c on every accepted sample, including ILLEGAL samples, so tracking re-anchors.
- Any non-ILLEGAL classification, including HOLD, clears cerr.
- ILLEGAL handling:
  - position and dir hold; err_pulse fires; err_count increments, saturating at 255; cerr increments.
  - When cerr reaches ERR_LIMIT, go to FAULT with locked <= 0.
- MAX_COUNT == 1: the overflow flag alone separates a wrap from a step; the priority order above is normative.
- Position arithmetic is modulo 2^EXT_WIDTH. 0 - 1 gives all-ones, with no flag.
- in_valid low: no state change and no pulses.

Decomposition:
- Package updown_tracker_pkg holds:
  - the state enum (UNLOCKED, TRACK, FAULT);
  - the step-class enum (HOLD, INC, DEC, WRAP_UP, WRAP_DN, ILLEGAL);
  - the err_count width constant (8).
- One natural combinational sub-module, updown_step_classifier (inputs prev, in_count, in_overflow; output is the step class).
- The top holds the FSM, position, counters and pulse registers.

Test Plan:
- Reset then lock:
  - Stimulus: rst pulse; in_valid with in_count=5.
  - Response: after reset all outputs 0. One cycle after the sample, locked=1, position=5, no pulses.
- Up wrap:
  - Stimulus: locked at 14; samples 15, then 0 with overflow=1.
  - Response: position 15 then 16; wrap_up_pulse once, step_pulse twice, dir=1.
- Down wrap from 0:
  - Stimulus: locked at 0; sample 15 with overflow=1.
  - Response: position=0xFFFF, wrap_dn_pulse, dir=0.
- Held flag:
  - Stimulus: after the wrap, repeat sample 0 with overflow=1 for 3 cycles.
  - Response: HOLD, with no err_pulse and position unchanged.
- Illegal to FAULT:
  - Stimulus: locked at 3; samples 7, 2, 9 (each a non-unit jump).
  - Response: err_count=3, FAULT, locked=0; a further sample of 10 is ignored.
- sync_req and in_valid in the same cycle:
  - Stimulus: sync_req together with in_valid and in_count=8; next cycle in_count=4.
  - Response: the first sample is discarded; locks with position=4 and err_count preserved.
